// File: rtl/sync_divider.sv
// sync_divider: programmable clock-enable divider that phase-aligns to an asynchronous sync pulse.
// Define SYNC_DIVIDER_MISS_DET_EN to compile in missing-sync detection while LOCKED.
module sync_divider #(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int MISS_LIMIT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 sync_in,
    input  logic                 err_clr,
    output logic                 div_out,
    output logic                 load,
    output logic                 load_val,
    output logic                 locked,
    output logic                 sync_err,
    output logic [DIV_WIDTH-1:0] phase
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(2);
    localparam logic [3:0]           LOCK_LAST = 4'(LOCK_COUNT - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_prev;
    logic                   sync_pulse;
    logic [DIV_WIDTH-1:0]   cnt;
    logic [DIV_WIDTH-1:0]   cnt_nxt;
    logic [DIV_WIDTH-1:0]   div_eff;
    logic [DIV_WIDTH-1:0]   div_eff_nxt;
    logic [DIV_WIDTH-1:0]   div_req;
    logic                   div_fresh;
    logic                   div_latch;
    logic [3:0]             match_cnt;
    logic [3:0]             match_nxt;
    logic                   wrap;
    logic                   aligned;
    logic                   realign;
    logic                   err_set;
    logic                   div_out_nxt;
    logic                   load_nxt;
    logic                   locked_nxt;
    logic                   sync_err_nxt;

`ifdef SYNC_DIVIDER_MISS_DET_EN
    localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);
    logic [3:0] miss_cnt;
    logic [3:0] miss_nxt;
`else
    logic [3:0] unused_miss_limit;
    assign unused_miss_limit = 4'(MISS_LIMIT);
`endif

    // Synchronizer chain plus a previous-value flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff   <= '0;
            sync_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], sync_in};
            sync_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync_pulse = sync_ff[SYNC_STAGES-1] & ~sync_prev;
    assign div_req    = (div < DIV_MIN) ? DIV_MIN : div;
    assign wrap       = (cnt >= (div_eff - DIV_WIDTH'(1)));
    assign aligned    = sync_pulse & wrap;

    // Next-state logic; a pulse landing on the natural wrap counts as aligned.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nxt = state;
        match_nxt = match_cnt;
        realign   = 1'b0;
        err_set   = 1'b0;
`ifdef SYNC_DIVIDER_MISS_DET_EN
        miss_nxt  = miss_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (sync_pulse) begin
                    realign   = 1'b1;
                    state_nxt = ST_TRACK;
                    match_nxt = '0;
                end
            end
            ST_TRACK: begin
                if (aligned) begin
                    if (match_cnt >= LOCK_LAST) begin
                        state_nxt = ST_LOCKED;
                        match_nxt = '0;
`ifdef SYNC_DIVIDER_MISS_DET_EN
                        miss_nxt  = '0;
`endif
                    end else begin
                        match_nxt = match_cnt + 4'd1;
                    end
                end else if (sync_pulse) begin
                    realign   = 1'b1;
                    match_nxt = '0;
                end
            end
            ST_LOCKED: begin
                if (sync_pulse && !aligned) begin
                    realign   = 1'b1;
                    err_set   = 1'b1;
                    state_nxt = ST_TRACK;
                    match_nxt = '0;
                end
`ifdef SYNC_DIVIDER_MISS_DET_EN
                else if (aligned) begin
                    miss_nxt = '0;
                end else if (wrap) begin
                    if (miss_cnt >= MISS_LAST) begin
                        err_set   = 1'b1;
                        state_nxt = ST_ACQUIRE;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt = miss_cnt + 4'd1;
                    end
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (!enable) begin
            state_nxt = ST_IDLE;
            match_nxt = '0;
            realign   = 1'b0;
            err_set   = 1'b0;
`ifdef SYNC_DIVIDER_MISS_DET_EN
            miss_nxt  = '0;
`endif
        end
    end

    // The ratio only changes where the counter restarts, so a period is never cut short.
    always_comb begin
        load_nxt    = realign;
        div_latch   = div_fresh | ((state != ST_IDLE) & (realign | wrap));
        div_eff_nxt = div_latch ? div_req : div_eff;
        if ((state == ST_IDLE) || (state_nxt == ST_IDLE) || realign || wrap) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + DIV_WIDTH'(1);
        end
        div_out_nxt  = (state_nxt != ST_IDLE) && (cnt_nxt < (div_eff_nxt >> 1));
        locked_nxt   = (state_nxt == ST_LOCKED);
        sync_err_nxt = err_set | (sync_err & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            div_eff   <= DIV_MIN;
            div_fresh <= 1'b1;
            match_cnt <= '0;
            div_out   <= 1'b0;
            load      <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
`ifdef SYNC_DIVIDER_MISS_DET_EN
            miss_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div_eff   <= div_eff_nxt;
            div_fresh <= 1'b0;
            match_cnt <= match_nxt;
            div_out   <= div_out_nxt;
            load      <= load_nxt;
            locked    <= locked_nxt;
            sync_err  <= sync_err_nxt;
`ifdef SYNC_DIVIDER_MISS_DET_EN
            miss_cnt  <= miss_nxt;
`endif
        end
    end

    assign phase    = cnt;
    assign load_val = 1'b1;

endmodule

// File: tb/tb_sync_divider.sv
// Directed bench for sync_divider: expected per-cycle snapshots are queued with the stimulus
// and popped/compared after every clock edge.
module tb_sync_divider;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] div;
    logic          sync_in;
    logic          err_clr;
    logic          div_out;
    logic          load;
    logic          load_val;
    logic          locked;
    logic          sync_err;
    logic [DW-1:0] phase;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [DW-1:0] phase;
        logic          div_out;
        logic          load;
        logic          locked;
        logic          sync_err;
    } snap_t;

    snap_t exp_q[$];

`ifdef SYNC_DIVIDER_MISS_DET_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    sync_divider #(
        .DIV_WIDTH  (DW),
        .SYNC_STAGES(2),
        .LOCK_COUNT (4),
        .MISS_LIMIT (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .div     (div),
        .sync_in (sync_in),
        .err_clr (err_clr),
        .div_out (div_out),
        .load    (load),
        .load_val(load_val),
        .locked  (locked),
        .sync_err(sync_err),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".phase"},    32'(phase),    32'd0);
        check({tag, ".div_out"},  32'(div_out),  32'd0);
        check({tag, ".load"},     32'(load),     32'd0);
        check({tag, ".load_val"}, 32'(load_val), 32'd1);
        check({tag, ".locked"},   32'(locked),   32'd0);
        check({tag, ".sync_err"}, 32'(sync_err), 32'd0);
    endtask

    // Queue n expected cycles of a free-running counter of period dv starting at ph0.
    task automatic push(input int n, input int ph0, input int dv, input bit ld_first,
                        input bit lk, input bit er, input bit run = 1'b1);
        snap_t s;
        int    ph;
        for (int i = 0; i < n; i++) begin
            ph         = run ? (ph0 + i) % dv : 0;
            s.phase    = DW'(ph);
            s.div_out  = run && (ph < dv / 2);
            s.load     = ld_first && (i == 0);
            s.locked   = lk;
            s.sync_err = er;
            exp_q.push_back(s);
        end
    endtask

    task automatic tick();
        snap_t e;
        @(posedge clk);
        #2;
        cyc++;
        n_cmp++;
        assert (exp_q.size() > 0) else begin
            n_bad++;
            $error("FAIL sb_underflow: cycle %0d observed no expected entry", cyc);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("c%0d.phase", cyc),    32'(phase),    32'(e.phase));
            check($sformatf("c%0d.div_out", cyc),  32'(div_out),  32'(e.div_out));
            check($sformatf("c%0d.load", cyc),     32'(load),     32'(e.load));
            check($sformatf("c%0d.locked", cyc),   32'(locked),   32'(e.locked));
            check($sformatf("c%0d.sync_err", cyc), 32'(sync_err), 32'(e.sync_err));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Raise sync_in after `pre` cycles for one cycle, then run `post` more cycles.
    task automatic sync_period(input int pre, input int post);
        ticks(pre);
        sync_in = 1'b1;
        ticks(1);
        sync_in = 1'b0;
        ticks(post);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lk_m;
        bit er_m;
        lk_m = !MISS_EN;
        er_m = MISS_EN;

        reset   = 1'b0;
        enable  = 1'b0;
        div     = DW'(8);
        sync_in = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset("rst0");

        // Free run at div=8, then an asynchronous reset mid-count.
        reset  = 1'b1;
        enable = 1'b1;
        push(12, 0, 8, 0, 0, 0);
        ticks(12);
        reset = 1'b0;
        #1;
        check_reset("rst_mid");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        // Counts 0..7, then one sync raised at phase 3 realigns two edges after first sample.
        push(4, 0, 8, 0, 0, 0);
        push(2, 4, 8, 0, 0, 0);
        push(8, 0, 8, 1, 0, 0);
        ticks(4);
        sync_in = 1'b1;
        ticks(1);
        sync_in = 1'b0;
        ticks(9);

        // Four aligned syncs: lock on the fourth, with no further load.
        for (int i = 0; i < 4; i++) begin
            push(8, 0, 8, 0, 0, 0);
            sync_period(6, 1);
        end
        push(8, 0, 8, 0, 1, 0);
        sync_period(6, 1);

        // A sync shifted by 3 cycles while locked; err_clr held at the same edge loses to the set.
        push(5, 0, 8, 0, 1, 0);
        ticks(3);
        sync_in = 1'b1;
        ticks(1);
        sync_in = 1'b0;
        ticks(1);
        err_clr = 1'b1;

        for (int j = 0; j < 4; j++) begin
            push(8, 0, 8, j == 0, 0, 1);
            if (j == 0) begin
                ticks(1);
                err_clr = 1'b0;
                sync_period(5, 1);
            end else begin
                sync_period(6, 1);
            end
        end

        // Relocked; err_clr clears sync_err, then syncs stop.
        push(2, 0, 8, 0, 1, 1);
        push(6, 2, 8, 0, 1, 0);
        ticks(2);
        err_clr = 1'b1;
        ticks(1);
        err_clr = 1'b0;
        ticks(5);
        push(8, 0, 8, 0, 1, 0);
        ticks(8);

        // Second wrap without sync; div=1 written mid-period only takes effect at the wrap.
        push(8, 0, 8, 0, lk_m, er_m);
        ticks(4);
        div = DW'(1);
        ticks(4);
        push(6, 0, 2, 0, lk_m, er_m);
        ticks(3);
        div = DW'(0);
        ticks(3);
        push(4, 0, 2, 0, lk_m, er_m);
        ticks(4);

        // Disable: idle, lock cleared, sync_err retained.
        enable = 1'b0;
        push(3, 0, 2, 0, 0, er_m, 1'b0);
        ticks(3);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("load_val_end", 32'(load_val), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_divider.md
# sync_divider

Programmable clock-enable divider that phase-aligns to an asynchronous external sync pulse and drives the synced-clock output register. It sits directly upstream of the output flip-flop stage. `div_out` feeds that stage's data input. `load`/`load_val` feed its synchronous reset/set pair, so the register snaps to a known level on every realignment. Lock and error status go to the board controller.

## Interface
- `DIV_WIDTH`, 16, width of divide ratio and phase counter
- `SYNC_STAGES`, 2, synchronizer depth for `sync_in` (≥2)
- `LOCK_COUNT`, 4, consecutive aligned syncs required to declare lock (1..15)
- `MISS_LIMIT`, 2, consecutive counter wraps without a sync before lock is dropped (1..15)

- `clk` in 1: sole clock
- `reset` in 1: asynchronous, active-low reset
- `enable` in 1: synchronous run enable
- `div` in DIV_WIDTH: period in `clk` cycles; values <2 are treated as 2
- `sync_in` in 1: asynchronous external sync, active on rising edge
- `err_clr` in 1: synchronous clear of `sync_err`
- `div_out` out 1: divided clock level
- `load` out 1: one-cycle load strobe to the downstream register
- `load_val` out 1: value to load, constant 1
- `locked` out 1: phase lock status
- `sync_err` out 1: sticky lock-loss flag
- `phase` out DIV_WIDTH: current counter value `cnt`

## Operation
- `sync_in` passes through a SYNC_STAGES flop chain plus one previous-value flop.
- `sync_pulse` = last stage & ~previous. This signal is internal and combinational.
- Divide ratio: `div_eff` = max(`div`, 2). It is latched at reset release, on every wrap, and on every realign; otherwise it is held.
- Counter `cnt` counts 0..`div_eff`−1 and wraps to 0.
- On any `sync_pulse` in a non-IDLE state, next `cnt` = 0. This is the realign.
- "Aligned" means `sync_pulse` arrives while `cnt` == `div_eff`−1.
- `div_out` is registered: `div_out` = (next `cnt` < `div_eff`>>1). Example: div=5 gives 2 high, 3 low.
- State machine:
  - **IDLE**: `cnt` held at 0, `div_out` 0, match and miss counters 0. Goes to ACQUIRE when `enable`=1.
  - **ACQUIRE**: counter free-runs. The first `sync_pulse` realigns, pulses `load`, and goes to TRACK with match=0.
  - **TRACK**: an aligned pulse increments match. When match reaches LOCK_COUNT, go to LOCKED and assert `locked`. A misaligned pulse realigns, pulses `load`, and sets match=0.
  - **LOCKED**: an aligned pulse clears miss. A misaligned pulse realigns, pulses `load`, sets `sync_err`, clears `locked`, and goes to TRACK with match=0. On a wrap with no pulse, miss increments. When miss reaches MISS_LIMIT, set `sync_err`, clear `locked`, and go to ACQUIRE.
- `enable`=0 in any state goes to IDLE on the next edge and clears `locked`. `sync_err` is retained.
- `sync_err` set takes priority over a simultaneous `err_clr`.
- An aligned pulse does not assert `load`. The downstream register is already in phase.

## Timing
- Reset values: `div_out`=0, `load`=0, `load_val`=1, `locked`=0, `sync_err`=0, `phase`=0. State is IDLE and the synchronizer is cleared.
- `sync_in` is first sampled high at edge E0. `sync_pulse` is high in the cycle after edge E0+SYNC_STAGES−1. The realign takes effect at edge E0+SYNC_STAGES, where `cnt`=0 and `load`=1 for exactly that one cycle.
- `div_out`, `phase` and `load` update on the same edge. The downstream register therefore sees `load` and the first post-realign `div_out` level together.
- `locked` rises on the edge that takes the LOCK_COUNT-th aligned pulse.
- A `sync_pulse` coinciding with a natural wrap counts as aligned, not as a miss.
- A `div` change is visible from the next wrap or realign only. There is no mid-period glitch.
- Asserting `reset` mid-operation forces all outputs to reset values immediately, without waiting for `clk`.

## Configuration
- `SYNC_DIVIDER_MISS_DET_EN` defined: missing-sync detection is compiled in as described above.
- Macro undefined: the miss counter is removed. LOCKED is left only via a misaligned pulse or `enable`=0, and a wrap with no pulse has no effect.

## Test plan
- Reset asserted mid-count with div=8 → all outputs are at reset values before the next `clk` edge. After release with `enable`=1, `phase` counts 0..7.
- div=8, one `sync_in` edge at `phase`=3, SYNC_STAGES=2 → `phase`=0 and `load`=1 for one cycle, 2 edges after first sample. `div_out` is 1 for 4 cycles, then 0 for 4.
- Syncs every 8 cycles, aligned, LOCK_COUNT=4 → `locked`=1 on the 4th aligned pulse. No `load` after the first realign.
- While locked, one sync shifted by 3 cycles → `load` pulse, `sync_err`=1, `locked`=0. Lock is regained after 4 further aligned syncs. `err_clr` then clears `sync_err`.
- Macro defined, locked, syncs stopped, MISS_LIMIT=2 → `locked`=0 and `sync_err`=1 at the 2nd wrap. Same stimulus with the macro undefined → `locked` stays 1.
- div=1 and div=0 → behave as div=2, with `div_out` toggling every cycle.
